writeback_sequencer: RTL and testbench
======================================

Name: writeback_sequencer

Overview:
- Last pipeline stage of the vector CPU.
- Accepts a 4-lane MEM/WB bundle and drives the shared register-file write port that the decode stage exposes: regWriteWB, resultWB, RdestW0..RdestW3.
- The decode register files share one 16-bit data bus, so lanes are written one per cycle. Non-selected lanes receive the null register address.
- Raises a stall while a bundle is still draining.

Parameters:
- DATA_W, 16, lane data width.
- LANES, 4, number of lanes/register files. Fixed at 4; other values are unsupported.
- NULL_REG, 4'h0, register address driven to idle lanes. Writes to it are discarded by the register files.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- valid_in  input  1  MEM/WB bundle valid
- ready_out  output  1  bundle accepted this cycle when valid_in&ready_out
- regWrite_in  input  1  bundle writes registers
- resultSrc_in  input  1  0=ALU result, 1=memory data
- laneMask_in  input  4  bit i=1: lane i is written
- rd_in  input  4  destination register
- alu0_in..alu3_in  input  16 each  per-lane ALU results
- mem0_in..mem3_in  input  16 each  per-lane memory data
- regWriteWB  output  1  register write enable
- resultWB  output  16  write data
- RdestW0..RdestW3  output  4 each  per-lane write address
- stallWB  output  1  high while draining; upstream stages hold

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, ready_out=1, regWriteWB=0, resultWB=0, RdestW*=NULL_REG, stallWB=0, holding register cleared.
  - Reset mid-drain abandons the remaining lanes with no further writes.
- Holding register, loaded on acceptance:
  - data[i] = resultSrc_in ? mem_i : alu_i
  - pending mask = laneMask_in & {4{regWrite_in}}
  - rd = rd_in
- States:
  - IDLE: ready_out=1. On accept with pending≠0, go to DRAIN. On accept with pending==0, stay in IDLE with no write. valid_in=0 stays in IDLE.
  - DRAIN: each cycle selects the lowest set pending bit k. Registered outputs for the next cycle: regWriteWB=1, resultWB=data[k], RdestWk=rd, all other RdestW=NULL_REG. Bit k is cleared. When the cleared mask reaches 0, DRAIN completes.
- Outputs are registered. The first write appears the cycle after acceptance. Total write cycles = popcount(pending), in ascending lane order.
- ready_out rule: high in IDLE, and in DRAIN during the cycle issuing the final lane. Back-to-back bundles therefore drain with no bubble. A bundle accepted in that final cycle begins writing the next cycle.
- stallWB = (state==DRAIN) & ~ready_out.
- In every cycle with no write: regWriteWB=0, RdestW*=NULL_REG, resultWB holds its last value.
- Input values are sampled only on acceptance. Changes while ready_out=0 are ignored.
- No arithmetic. Data passes through at 16 bits with no modification.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with valid_in=0 → ready_out=1, regWriteWB=0, RdestW0..3=0, stallWB=0.
- Full ALU bundle: valid, regWrite=1, resultSrc=0, mask=4'hF, rd=5, alu={0x1111,0x2222,0x3333,0x4444} → four consecutive writes starting the next cycle: (RdestW0=5, 0x1111), (RdestW1=5, 0x2222), (RdestW2=5, 0x3333), (RdestW3=5, 0x4444). stallWB=1 for 3 cycles. Idle lanes read 0.
- Sparse memory bundle: mask=4'b1010, resultSrc=1, rd=9, mem1=0xBEEF, mem3=0xCAFE → exactly two writes, lane1=0xBEEF then lane3=0xCAFE. ready_out=1 on the second write.
- Back-to-back: second bundle (mask=4'h1, rd=2, alu0=0x00AA) held valid during the first bundle's final write → written the very next cycle with no idle gap.
- No-write bundles: regWrite_in=0 with mask=F, and regWrite_in=1 with mask=0 → accepted immediately, regWriteWB stays 0, state stays IDLE.
- Reset mid-drain: assert rst=0 after the 2nd of 4 writes → no lane2/lane3 writes, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/writeback_sequencer.sv
// Final pipeline stage: serialises a 4-lane MEM/WB bundle onto the
// shared register-file write port, one lane per cycle.
module writeback_sequencer #(
  parameter int         DATA_W   = 16,
  parameter int         LANES    = 4,
  parameter logic [3:0] NULL_REG = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              regWrite_in,
  input  logic              resultSrc_in,
  input  logic [LANES-1:0]  laneMask_in,
  input  logic [3:0]        rd_in,
  input  logic [DATA_W-1:0] alu0_in,
  input  logic [DATA_W-1:0] alu1_in,
  input  logic [DATA_W-1:0] alu2_in,
  input  logic [DATA_W-1:0] alu3_in,
  input  logic [DATA_W-1:0] mem0_in,
  input  logic [DATA_W-1:0] mem1_in,
  input  logic [DATA_W-1:0] mem2_in,
  input  logic [DATA_W-1:0] mem3_in,
  output logic              regWriteWB,
  output logic [DATA_W-1:0] resultWB,
  output logic [3:0]        RdestW0,
  output logic [3:0]        RdestW1,
  output logic [3:0]        RdestW2,
  output logic [3:0]        RdestW3,
  output logic              stallWB
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t state;

  logic [DATA_W-1:0] data_q [LANES];
  logic [LANES-1:0]  pend_q;
  logic [3:0]        rd_q;

  logic              accept;
  logic [LANES-1:0]  pend_in;
  logic [DATA_W-1:0] data_in [LANES];

  logic [LANES-1:0]  sel_mask;
  logic [LANES-1:0]  pick;
  logic [LANES-1:0]  pend_nxt;
  logic              pick_any;
  logic [3:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    accept     = valid_in & ready_out;
    pend_in    = laneMask_in & {LANES{regWrite_in}};
    data_in[0] = resultSrc_in ? mem0_in : alu0_in;
    data_in[1] = resultSrc_in ? mem1_in : alu1_in;
    data_in[2] = resultSrc_in ? mem2_in : alu2_in;
    data_in[3] = resultSrc_in ? mem3_in : alu3_in;
  end

  // Accepting bundle issues its first lane straight from the inputs,
  // so the first write lands the cycle after acceptance.
  always_comb begin
    sel_mask = '0;
    sel_rd   = rd_q;
    if (accept) begin
      sel_mask = pend_in;
      sel_rd   = rd_in;
    end else if (state == DRAIN) begin
      sel_mask = pend_q;
    end
    pick     = sel_mask & (~sel_mask + LANES'(1));
    pick_any = |sel_mask;
    pend_nxt = sel_mask & ~pick;
  end

  always_comb begin
    sel_data = '0;
    unique case (1'b1)
      pick[0]: sel_data = accept ? data_in[0] : data_q[0];
      pick[1]: sel_data = accept ? data_in[1] : data_q[1];
      pick[2]: sel_data = accept ? data_in[2] : data_q[2];
      pick[3]: sel_data = accept ? data_in[3] : data_q[3];
      default: sel_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ready_out  <= 1'b1;
      stallWB    <= 1'b0;
      regWriteWB <= 1'b0;
      resultWB   <= '0;
      RdestW0    <= NULL_REG;
      RdestW1    <= NULL_REG;
      RdestW2    <= NULL_REG;
      RdestW3    <= NULL_REG;
      pend_q     <= '0;
      rd_q       <= '0;
      for (int i = 0; i < LANES; i++)
        data_q[i] <= '0;
    end else begin
      if (accept) begin
        rd_q <= rd_in;
        for (int i = 0; i < LANES; i++)
          data_q[i] <= data_in[i];
      end
      pend_q <= pend_nxt;
      unique case (state)
        IDLE:  state <= (accept && |pend_nxt) ? DRAIN : IDLE;
        DRAIN: state <= (|pend_nxt) ? DRAIN : IDLE;
        default: state <= IDLE;
      endcase
      // Ready rises with the final lane so the next bundle follows
      // without a bubble.
      ready_out  <= ~|pend_nxt;
      stallWB    <= |pend_nxt;
      regWriteWB <= pick_any;
      if (pick_any)
        resultWB <= sel_data;
      RdestW0 <= pick[0] ? sel_rd : NULL_REG;
      RdestW1 <= pick[1] ? sel_rd : NULL_REG;
      RdestW2 <= pick[2] ? sel_rd : NULL_REG;
      RdestW3 <= pick[3] ? sel_rd : NULL_REG;
    end
  end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboard bench for writeback_sequencer: expected writes are queued
// on acceptance and consumed by a negedge monitor.
module tb_writeback_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        regWrite_in = 1'b0;
  logic        resultSrc_in = 1'b0;
  logic [3:0]  laneMask_in = 4'h0;
  logic [3:0]  rd_in = 4'h0;
  logic [15:0] alu0_in = 0, alu1_in = 0, alu2_in = 0, alu3_in = 0;
  logic [15:0] mem0_in = 0, mem1_in = 0, mem2_in = 0, mem3_in = 0;
  logic        ready_out, regWriteWB, stallWB;
  logic [15:0] resultWB;
  logic [3:0]  RdestW0, RdestW1, RdestW2, RdestW3;
  logic [3:0]  rdw [4];

  assign rdw[0] = RdestW0;
  assign rdw[1] = RdestW1;
  assign rdw[2] = RdestW2;
  assign rdw[3] = RdestW3;

  writeback_sequencer dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .ready_out(ready_out),
    .regWrite_in(regWrite_in), .resultSrc_in(resultSrc_in),
    .laneMask_in(laneMask_in), .rd_in(rd_in),
    .alu0_in(alu0_in), .alu1_in(alu1_in),
    .alu2_in(alu2_in), .alu3_in(alu3_in),
    .mem0_in(mem0_in), .mem1_in(mem1_in),
    .mem2_in(mem2_in), .mem3_in(mem3_in),
    .regWriteWB(regWriteWB), .resultWB(resultWB),
    .RdestW0(RdestW0), .RdestW1(RdestW1),
    .RdestW2(RdestW2), .RdestW3(RdestW3),
    .stallWB(stallWB)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [3:0]  rd;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    bit          rw;
    bit          src;
    logic [3:0]  mask;
    logic [3:0]  rd;
    logic [15:0] alu [4];
    logic [15:0] mem [4];
  } bun_t;

  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  logic rst_seen;
  logic [15:0] last_data = 16'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference: each written lane in ascending order, data picked by source.
  task automatic push_bundle(bun_t b);
    wr_t w;
    if (b.rw)
      for (int i = 0; i < 4; i++)
        if (b.mask[i]) begin
          w.lane = i;
          w.rd   = b.rd;
          w.data = b.src ? b.mem[i] : b.alu[i];
          exp_q.push_back(w);
        end
  endtask

  task automatic apply(bun_t b);
    regWrite_in  = b.rw;
    resultSrc_in = b.src;
    laneMask_in  = b.mask;
    rd_in        = b.rd;
    alu0_in = b.alu[0]; alu1_in = b.alu[1];
    alu2_in = b.alu[2]; alu3_in = b.alu[3];
    mem0_in = b.mem[0]; mem1_in = b.mem[1];
    mem2_in = b.mem[2]; mem3_in = b.mem[3];
  endtask

  function automatic bun_t rand_bun();
    bun_t b;
    b.rw   = ($urandom_range(0, 4) != 0);
    b.src  = 1'($urandom);
    b.mask = 4'($urandom);
    b.rd   = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      b.alu[i] = 16'($urandom);
      b.mem[i] = 16'($urandom);
    end
    return b;
  endfunction

  function automatic bun_t mk(bit rw, bit src, logic [3:0] mask,
                              logic [3:0] rd, logic [63:0] dat);
    bun_t b;
    b.rw = rw; b.src = src; b.mask = mask; b.rd = rd;
    for (int i = 0; i < 4; i++) begin
      b.alu[i] = src ? 16'($urandom) : dat[16*i +: 16];
      b.mem[i] = src ? dat[16*i +: 16] : 16'($urandom);
    end
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(bun_t b, bit scramble);
    int n = 0;
    apply(b);
    valid_in = 1'b1;
    forever begin
      #6;
      if (ready_out === 1'b1) begin
        push_bundle(b);
        break;
      end
      n++;
      if (n > 16) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=%b required=1", ready_out);
        break;
      end
      @(posedge clk);
      #1;
      if (scramble) begin
        b = rand_bun();
        apply(b);
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) begin
    started  <= 1'b1;
    rst_seen <= rst;
  end

  task automatic monitor_cycle();
    wr_t w;
    logic [3:0] ea;
    if (!rst_seen) begin
      exp_q.delete();
      last_data = 16'h0;
    end
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      chk("regwrite_on", 32'(regWriteWB), 1);
      chk("result", 32'(resultWB), 32'(w.data));
      for (int i = 0; i < 4; i++) begin
        ea = (i == w.lane) ? w.rd : 4'h0;
        chk($sformatf("rdest%0d", i), 32'(rdw[i]), 32'(ea));
      end
      last_data = w.data;
      chk("ready_drain", 32'(ready_out), 32'(exp_q.size() == 0));
      chk("stall_drain", 32'(stallWB), 32'(exp_q.size() != 0));
    end else begin
      chk("regwrite_off", 32'(regWriteWB), 0);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rdest%0d_idle", i), 32'(rdw[i]), 0);
      chk("ready_idle", 32'(ready_out), 1);
      chk("stall_idle", 32'(stallWB), 0);
      chk("result_hold", 32'(resultWB), 32'(last_data));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started) monitor_cycle();
    end
  end

  initial begin
    bun_t b;
    int n;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    send(mk(1, 0, 4'hF, 4'd5, 64'h4444_3333_2222_1111), 0);
    idle(5);

    send(mk(1, 1, 4'b1010, 4'd9, 64'hCAFE_0000_BEEF_0000), 0);
    idle(3);

    send(mk(1, 0, 4'hF, 4'd7, 64'h0D0C_0B0A_0908_0706), 0);
    send(mk(1, 0, 4'h1, 4'd2, 64'h0000_0000_0000_00AA), 0);
    idle(3);

    send(mk(0, 0, 4'hF, 4'd3, 64'h1234_5678_9ABC_DEF0), 0);
    send(mk(1, 1, 4'h0, 4'd4, 64'h1234_5678_9ABC_DEF0), 0);
    idle(3);

    send(mk(1, 0, 4'hF, 4'd6, 64'hA004_A003_A002_A001), 0);
    @(posedge clk);
    #6;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);

    repeat (300) begin
      b = rand_bun();
      send(b, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
